// File: rtl/flt_pkg.sv
// Shared types and constants for the half-float to Q8.8 converter.
// Used by flt_to_fix and flt_to_fix_shift.
package flt_pkg;

    localparam int EXP_W    = 5;
    localparam int MANT_W   = 10;
    localparam int FIX_W    = 16;
    localparam int FIX_FRAC = 8;
    localparam int FLT_BIAS = 15;

    // Exponent at which {1,mant} is already aligned to Q8.8
    localparam logic [EXP_W-1:0] EXP_Q   = EXP_W'(FLT_BIAS + MANT_W - FIX_FRAC);
    // Exponent from which the magnitude no longer fits in Q8.8
    localparam logic [EXP_W-1:0] EXP_SAT = EXP_W'(FLT_BIAS + MANT_W - FIX_FRAC + FIX_W - MANT_W - 1);

    localparam logic [EXP_W-1:0] L_CAP = 5'd5;
    localparam logic [EXP_W-1:0] R_CAP = 5'd12;

    localparam logic [FIX_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [FIX_W-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        RD_HI,
        RD_LO,
        SHIFT,
        FIX,
        WR_HI,
        WR_LO
    } state_t;

    // Number of one-bit shift cycles needed for a given exponent
    function automatic logic [3:0] shift_cnt(input logic [EXP_W-1:0] e);
        logic [EXP_W-1:0] d;
        if (e >= EXP_Q) begin
            d = e - EXP_Q;
            shift_cnt = (d > L_CAP) ? L_CAP[3:0] : d[3:0];
        end else begin
            d = EXP_Q - e;
            shift_cnt = (d > R_CAP) ? R_CAP[3:0] : d[3:0];
        end
    endfunction

endpackage

// File: rtl/flt_to_fix_shift.sv
// Serial magnitude shifter, one bit per step, left or right.
// FLT2FIX_ROUND_EN adds guard/sticky tracking and round-half-even.
module flt_to_fix_shift (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              left,
    input  logic [10:0]       m_in,
    output logic [16:0]       mag
);
    import flt_pkg::*;

    logic [FIX_W-1:0] val;

`ifdef FLT2FIX_ROUND_EN
    logic guard;
    logic sticky;

    // Load the significand, then shift while keeping the bits shifted out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val    <= '0;
            guard  <= 1'b0;
            sticky <= 1'b0;
        end else if (load) begin
            val    <= {{(FIX_W-MANT_W-1){1'b0}}, m_in};
            guard  <= 1'b0;
            sticky <= 1'b0;
        end else if (step) begin
            if (left) begin
                val <= {val[FIX_W-2:0], 1'b0};
            end else begin
                val    <= {1'b0, val[FIX_W-1:1]};
                guard  <= val[0];
                sticky <= sticky | guard;
            end
        end
    end

    assign mag = {1'b0, val} + {{FIX_W{1'b0}}, guard & (sticky | val[0])};
`else
    // Load the significand, then shift; dropped bits are discarded
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val <= '0;
        end else if (load) begin
            val <= {{(FIX_W-MANT_W-1){1'b0}}, m_in};
        end else if (step) begin
            if (left) val <= {val[FIX_W-2:0], 1'b0};
            else      val <= {1'b0, val[FIX_W-1:1]};
        end
    end

    assign mag = {1'b0, val};
`endif

endmodule

// File: rtl/flt_to_fix.sv
// Memory-mapped half-float to Q8.8 converter: read, shift, fix, write.
// Optional FLT2FIX_ROUND_EN selects round-to-nearest-even on right shifts.
module flt_to_fix #(
    parameter logic [7:0] IN_ADDR  = 8'd128,
    parameter logic [7:0] OUT_ADDR = 8'd130
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);
    import flt_pkg::*;

    state_t state, nxt;

    logic [7:0]       hi;
    logic [3:0]       cnt;
    logic [FIX_W-1:0] result;
    logic [FIX_W-1:0] fix_val;
    logic [FIX_W:0]   mag;
    logic [EXP_W-1:0] e;
    logic             sign;
    logic             skip;
    logic             ld;
    logic             stp;

    assign sign = hi[7];
    assign e    = hi[6:2];
    assign skip = (e == EXP_Q) | (e == '0) | (e == '1);

    flt_to_fix_shift u_shift (
        .clk   (clk),
        .reset (reset),
        .load  (ld),
        .step  (stp),
        .left  (e >= EXP_Q),
        .m_in  ({1'b1, hi[1:0], mem_rdata}),
        .mag   (mag)
    );

    // Special exponents, saturation and sign application
    always_comb begin
        fix_val = '0;
        if (e == '0) begin
            fix_val = '0;
        end else if ((e == '1) || (e >= EXP_SAT)) begin
            fix_val = sign ? SAT_NEG : SAT_POS;
        end else if (mag > {1'b0, SAT_POS}) begin
            fix_val = sign ? SAT_NEG : SAT_POS;
        end else if (sign) begin
            fix_val = ~mag[FIX_W-1:0] + 16'd1;
        end else begin
            fix_val = mag[FIX_W-1:0];
        end
    end

    // Next-state and memory strobes
    always_comb begin
        nxt       = state;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ld        = 1'b0;
        stp       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) nxt = RD_HI;
            end
            RD_HI: begin
                mem_rd   = 1'b1;
                mem_addr = IN_ADDR;
                nxt      = RD_LO;
            end
            RD_LO: begin
                mem_rd   = 1'b1;
                mem_addr = IN_ADDR + 8'd1;
                ld       = 1'b1;
                nxt      = skip ? FIX : SHIFT;
            end
            SHIFT: begin
                stp = 1'b1;
                if (cnt == 4'd1) nxt = FIX;
            end
            FIX: begin
                nxt = WR_HI;
            end
            WR_HI: begin
                mem_wr    = 1'b1;
                mem_addr  = OUT_ADDR;
                mem_wdata = result[15:8];
                nxt       = WR_LO;
            end
            WR_LO: begin
                mem_wr    = 1'b1;
                mem_addr  = OUT_ADDR + 8'd1;
                mem_wdata = result[7:0];
                nxt       = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // State, captured operand, shift counter, result and done flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            hi     <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state <= nxt;
            if (state == RD_HI) hi <= mem_rdata;
            if (state == RD_LO) cnt <= shift_cnt(e);
            if (state == SHIFT) cnt <= cnt - 4'd1;
            if (state == FIX) result <= fix_val;
            if ((state == IDLE) && start) done <= 1'b0;
            else if (state == WR_LO) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_flt_to_fix.sv
// Self-checking bench for flt_to_fix with a byte memory model.
// Expected results are queued at start and checked at done.
module tb_flt_to_fix;

    logic       clk;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] in_mem  [256];
    logic [7:0] out_mem [256];
    int wr_cnt;
    int rdhi_cnt;
    int overlap;

    int checks;
    int passes;

    typedef struct {
        logic [15:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];

    flt_to_fix dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = in_mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr) begin
            out_mem[mem_addr] <= mem_wdata;
            if (mem_addr == 8'd130 || mem_addr == 8'd131)
                wr_cnt <= wr_cnt + 1;
        end
        if (mem_rd && mem_addr == 8'd128)
            rdhi_cnt <= rdhi_cnt + 1;
    end

    always @(negedge clk) begin
        if (mem_rd && mem_wr) overlap <= overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [15:0] model(input logic [7:0] h,
                                          input logic [7:0] l);
        int     e;
        longint m;
        longint q;
        int     k;
        bit     s;
`ifdef FLT2FIX_ROUND_EN
        longint rem;
        longint half;
`endif
        s = h[7];
        e = int'(h[6:2]);
        m = 1024 + longint'({h[1:0], l});
        if (e == 0) return 16'h0000;
        if (e == 31) return s ? 16'h8000 : 16'h7FFF;
        if (e >= 17) begin
            q = m << (e - 17);
        end else begin
            k = 17 - e;
            q = m >> k;
`ifdef FLT2FIX_ROUND_EN
            rem  = m - (q << k);
            half = longint'(1) << (k - 1);
            if (rem > half || (rem == half && q[0])) q++;
`endif
        end
        if (!s && q > 32767) return 16'h7FFF;
        if (s && q > 32768) return 16'h8000;
        return s ? 16'(-q) : 16'(q);
    endfunction

    function automatic int lat_model(input logic [7:0] h);
        int e;
        int n;
        e = int'(h[6:2]);
        if (e == 0 || e == 31 || e == 17) n = 0;
        else if (e > 17) n = (e - 17 > 5) ? 5 : e - 17;
        else n = (17 - e > 12) ? 12 : 17 - e;
        return 6 + n;
    endfunction

    task automatic run_conv(input logic [7:0] h, input logic [7:0] l,
                            input string tag);
        exp_t x;
        int   lat;
        int   w0;
        in_mem[128] = h;
        in_mem[129] = l;
        x.res = model(h, l);
        x.lat = lat_model(h);
        sb.push_back(x);
        w0 = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        x = sb.pop_front();
        chk({tag, "_res"}, {16'h0, out_mem[130], out_mem[131]}, {16'h0, x.res});
        chk({tag, "_lat"}, lat, x.lat);
        chk({tag, "_wr"}, wr_cnt - w0, 2);
    endtask

    initial begin
        int w0;
        int r0;
        int p;
        checks   = 0;
        passes   = 0;
        wr_cnt   = 0;
        rdhi_cnt = 0;
        overlap  = 0;
        for (int i = 0; i < 256; i++) in_mem[i] = 8'h00;
        reset = 1'b0;
        start = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_done",  {31'h0, done}, 0);
        chk("rst_rd",    {31'h0, mem_rd}, 0);
        chk("rst_wr",    {31'h0, mem_wr}, 0);
        chk("rst_addr",  {24'h0, mem_addr}, 0);
        chk("rst_wdata", {24'h0, mem_wdata}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_conv(8'h3C, 8'h00, "one");
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", {31'h0, done}, 1);
        run_conv(8'hC5, 8'h00, "neg5");
        run_conv(8'h5B, 8'hFF, "satp");
        run_conv(8'hDB, 8'hFF, "satn");
        run_conv(8'h7C, 8'h00, "inf");
        run_conv(8'h00, 8'h01, "denorm");
        run_conv(8'h1C, 8'h00, "tiny");
        run_conv(8'h1A, 8'h00, "tie");
        run_conv(8'h4A, 8'h80, "p13");
        run_conv(8'hB8, 8'h00, "nhalf");
        run_conv(8'h59, 8'hFF, "maxl");
        run_conv(8'hBD, 8'h55, "nfrac");
        run_conv(8'h3D, 8'h03, "frac");
        run_conv(8'h80, 8'h00, "negz");

        w0 = wr_cnt;
        in_mem[128] = 8'h04;
        in_mem[129] = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_done", {31'h0, done}, 0);
        chk("abort_wr",   {31'h0, mem_wr}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_nowr", wr_cnt - w0, 0);
        run_conv(8'h3C, 8'h00, "after");

        in_mem[128] = 8'h3C;
        in_mem[129] = 8'h00;
        p  = lat_model(8'h3C);
        w0 = wr_cnt;
        r0 = rdhi_cnt;
        @(negedge clk);
        start = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("held_conv", rdhi_cnt - r0, (20 + p - 1) / p);
        chk("held_wr",   wr_cnt - w0, 2 * ((20 + p - 1) / p));
        chk("held_done", {31'h0, done}, 1);
        chk("held_res", {16'h0, out_mem[130], out_mem[131]}, 32'h0100);
        chk("rdwr_excl", overlap, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/flt_to_fix.md
FLT_TO_FIX -- requirements
Module: flt_to_fix

Interface
REQ-001 SHALL have parameter IN_ADDR, default 8'd128, byte address of input float MSB (LSB at IN_ADDR+1).
REQ-002 SHALL have parameter OUT_ADDR, default 8'd130, byte address of result MSB (LSB at OUT_ADDR+1).
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, conversion request sampled in IDLE.
REQ-006 SHALL have port done, output, 1, level; high when the last conversion has completed.
REQ-007 SHALL have port mem_addr, output, 8, data_mem byte address.
REQ-008 SHALL have port mem_rd, output, 1, read enable.
REQ-009 SHALL have port mem_wr, output, 1, write enable.
REQ-010 SHALL have port mem_wdata, output, 8, write data.
REQ-011 SHALL have port mem_rdata, input, 8, combinational read data for the current mem_addr.

Function
REQ-012 SHALL convert a half-precision float (sign[15], exp[14:10], mant[9:0], bias 15) to 16-bit two's-complement Q8.8.
REQ-013 SHALL form M = {1,mant} (11 bits); magnitude = M shifted left (e-17) when e>=17, right (17-e) when e<17.
REQ-014 SHALL use states IDLE->RD_HI->RD_LO->SHIFT->FIX->WR_HI->WR_LO->IDLE.
REQ-015 RD_HI/RD_LO SHALL drive mem_rd=1 with IN_ADDR/IN_ADDR+1 and capture mem_rdata at the clock edge ending the state.
REQ-016 SHALL perform 1 bit of shift per cycle in SHIFT; SHIFT is skipped when e==17 or when e==0 or e==31.
REQ-017 Right shifts SHALL be capped at 12 cycles (result already zero); left shifts SHALL be capped at 5 cycles.
REQ-018 e==0 (zero/denormal) SHALL yield 0x0000; e==31 SHALL saturate per sign.
REQ-019 SHALL saturate: e>=22 or e==31 gives 0x7FFF when positive, 0x8000 when negative.
REQ-020 FIX SHALL negate the magnitude when sign=1; -0 SHALL yield 0x0000.
REQ-021 WR_HI/WR_LO SHALL drive mem_wr=1 with result[15:8] to OUT_ADDR and result[7:0] to OUT_ADDR+1.
REQ-022 mem_rd and mem_wr SHALL never be high together; both SHALL be low in IDLE and in SHIFT.
REQ-023 done SHALL fall the cycle start is accepted and rise the cycle after WR_LO; it SHALL hold until the next accepted start.
REQ-024 start while not in IDLE SHALL be ignored.
REQ-025 Total latency SHALL be 6 cycles plus the shift count (start edge to done high).

Reset
REQ-026 While reset=0: state=IDLE, done=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, all internal registers 0.
REQ-027 Reset mid-conversion SHALL abort immediately, with no further memory write.

Configuration
REQ-028 FLT2FIX_ROUND_EN defined: right shifts SHALL track guard and sticky bits and round to nearest, ties to even, before FIX.
REQ-029 Under FLT2FIX_ROUND_EN, rounding that carries the magnitude past 0x7FFF SHALL saturate; latency is unchanged.
REQ-030 FLT2FIX_ROUND_EN undefined: SHALL truncate toward zero and carry no guard/sticky logic.

Structure
REQ-031 Package flt_pkg SHALL hold the state enum, FLT_BIAS=15, EXP_W=5, MANT_W=10, FIX_W=16, FIX_FRAC=8, and the saturation constants.
REQ-032 Shift and guard/sticky logic SHALL be sub-module flt_to_fix_shift; the FSM and memory sequencing SHALL stay in flt_to_fix.

Verification
REQ-033 mem[128:129]=3C 00 (1.0), start -> mem[130:131]=01 00, done high 8 cycles after start.
REQ-034 C5 00 (-5.0) -> FB 00, SHIFT skipped, latency 6 cycles.
REQ-035 5B FF -> 7F FF; DB FF -> 80 00; 7C 00 -> 7F FF; 00 01 -> 00 00.
REQ-036 1C 00 -> 00 01; 1A 00 -> 00 00 without the macro, 00 01 with FLT2FIX_ROUND_EN.
REQ-037 reset pulsed low during SHIFT -> done=0, no write to 130/131, next start converts correctly.
REQ-038 start held high for 20 cycles -> exactly one conversion per return to IDLE; mem_rd and mem_wr never high together.
